dir_input_queue: RTL and testbench
==================================

// Module: dir_input_queue
// PURPOSE
//  Player-input front end feeding snake_controller's direction inputs.
//  - Synchronises and debounces the four raw direction switches.
//  - Turns each press into a one-cycle strobe and filters illegal turns.
//  - Buffers accepted turns in a small FIFO and commits one per game tick (refresh).
//  - Rapid presses between frames are applied on successive frames, not lost.
// PARAMETERS
//  DEBOUNCE_CYCLES  250000  consecutive stable vga_clk cycles before a debounced level changes (10 ms @25 MHz)
//  QUEUE_DEPTH      2       pending-turn FIFO entries; power of two, 2..8
//  RESET_DIR        2'b11   direction loaded at reset (00 up, 01 down, 10 left, 11 right)
// PORTS
//  vga_clk      in   1  sole clock
//  rst          in   1  synchronous, active-high reset
//  refresh      in   1  one-cycle game-tick strobe (vga_clk domain)
//  sw_up        in   1  raw switch, asynchronous, active-high
//  sw_down      in   1  raw switch, asynchronous, active-high
//  sw_left      in   1  raw switch, asynchronous, active-high
//  sw_right     in   1  raw switch, asynchronous, active-high
//  dir          out  2  committed direction, drives snake_controller
//  turn_pulse   out  1  high one cycle after a commit
//  pending      out  4  FIFO occupancy, 0..QUEUE_DEPTH
//  drop_pulse   out  1  high one cycle when an accepted-class press is dropped (FIFO full)
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - dir=RESET_DIR; turn_pulse=0; drop_pulse=0; pending=0.
//   - Sync flops, debounced levels and counters cleared to 0.
//   - Applies mid-operation; queued turns are discarded.
//  Input conditioning:
//   - Each switch passes through a 2-flop synchroniser.
//   - Per-switch counter: zeroed when sync level == debounced level, else increments.
//   - When the count reaches DEBOUNCE_CYCLES-1, debounced takes the sync level and the counter clears.
//   - Press strobe = debounced rising edge; lasts one cycle.
//   - Releases are ignored.
//  Arbitration: if several strobes fire in one cycle, only the highest priority is taken.
//   - Priority: up > down > left > right. Others are silently ignored and do not raise drop_pulse.
//  Validation reference: REF = newest FIFO entry if pending>0, else dir.
//   - A strobe equal to REF is rejected: no enqueue, no drop_pulse.
//   - A strobe opposite REF (up/down, left/right) is handled per CONFIGURATION.
//  Enqueue: the valid strobe is written at the tail; pending updates the next cycle.
//   - If pending==QUEUE_DEPTH and no pop occurs this cycle: drop, and drop_pulse=1 next cycle.
//  Commit: on refresh with pending>0:
//   - Pop the head into dir; turn_pulse=1 the next cycle.
//   - If pending==0, refresh does nothing.
//  Simultaneous pop and enqueue:
//   - Both occur; pending is unchanged.
//   - A full FIFO accepts the press, since the pop frees a slot.
//   - REF is still the pre-pop newest entry.
//  Pointer rules:
//   - Read/write pointers are log2(QUEUE_DEPTH) bits and wrap modulo depth.
//   - Full/empty are taken from the pending count, never from pointer equality.
// CONFIGURATION
//  DIR_REVERSE_LOCK_EN defined:
//   - A strobe opposite REF is rejected like a same-direction press, so the snake cannot fold onto itself.
//  DIR_REVERSE_LOCK_EN undefined:
//   - Opposite strobes are enqueued normally; collision logic downstream handles them.
// TESTING
//  1 Reset: rst high 2 cycles -> dir=11, pending=0, turn_pulse=0, drop_pulse=0.
//  2 Debounce (DEBOUNCE_CYCLES=4): sw_up glitch 3 cycles -> no enqueue.
//    Held 8 cycles -> pending=1; next refresh -> dir=00 and a 1-cycle turn_pulse.
//  3 Queue (dir=11): press up, then left before refresh -> pending=2.
//    Third press down -> drop_pulse=1, pending stays 2.
//    Two refreshes -> dir=00, then dir=10.
//  4 Reverse lock (dir=11, macro defined): press left -> pending stays 0.
//    Macro undefined -> pending=1; refresh -> dir=10.
//  5 Full FIFO (depth 2) + refresh + new press in the same cycle:
//    -> press accepted, pending stays 2, no drop_pulse.
//  6 Simultaneous up+right strobes -> only up enqueued.
//    Then rst mid-queue -> pending=0, dir=11.

Source files
------------

// File: rtl/dir_input_queue.sv
// Player direction front end: synchronise and debounce four switches, filter turns, queue them,
// and commit one queued turn per game tick. Build macro DIR_REVERSE_LOCK_EN also rejects reversals.
module dir_input_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned QUEUE_DEPTH     = 2,
    parameter logic [1:0]  RESET_DIR       = 2'b11
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       refresh,
    input  logic       sw_up,
    input  logic       sw_down,
    input  logic       sw_left,
    input  logic       sw_right,
    output logic [1:0] dir,
    output logic       turn_pulse,
    output logic [3:0] pending,
    output logic       drop_pulse
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       DEPTH_CNT = 4'(QUEUE_DEPTH);

    // Switch index doubles as the direction code: 0 up, 1 down, 2 left, 3 right.
    logic [3:0]       sw_raw;
    logic [3:0]       sync_q1;
    logic [3:0]       sync_q2;
    logic [3:0]       deb;
    logic [3:0]       deb_prev;
    logic [3:0]       strobe;
    logic [CNT_W-1:0] cnt [4];

    logic [1:0]       fifo [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic             sel_valid;
    logic [1:0]       sel_dir;
    logic [1:0]       ref_dir;
    logic             reject;
    logic             pop;
    logic             full;
    logic             push;
    logic             drop;

    assign sw_raw = {sw_right, sw_left, sw_down, sw_up};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= sw_raw;
            sync_q2 <= sync_q1;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (rst) begin
            deb      <= '0;
            deb_prev <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < 4; i++) begin
                if (sync_q2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync_q2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign strobe = deb & ~deb_prev;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_valid = 1'b0;
        sel_dir   = 2'b00;
        for (int i = 3; i >= 0; i--) begin
            if (strobe[i]) begin
                sel_valid = 1'b1;
                sel_dir   = 2'(i);
            end
        end
    end

    // New presses are validated against the newest queued turn, not the committed one.
    assign ref_dir = (pending != 4'd0) ? fifo[wr_ptr - PTR_W'(1)] : dir;

    always_comb begin
        reject = (sel_dir == ref_dir);
`ifdef DIR_REVERSE_LOCK_EN
        if (sel_dir == (ref_dir ^ 2'b01)) reject = 1'b1;
`endif
    end

    assign pop  = refresh && (pending != 4'd0);
    assign full = (pending == DEPTH_CNT);
    assign push = sel_valid && !reject && (!full || pop);
    assign drop = sel_valid && !reject && full && !pop;

    // Full/empty come from the count; pointers wrap naturally since the depth is a power of two.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            pending    <= '0;
            dir        <= RESET_DIR;
            turn_pulse <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            turn_pulse <= pop;
            drop_pulse <= drop;
            if (pop) begin
                dir    <= fifo[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (push && !pop) begin
                pending <= pending + 4'd1;
            end else if (pop && !push) begin
                pending <= pending - 4'd1;
            end
        end
    end

    // NOTE: storage is not reset; reset empties the queue through the pointers and count.
    always_ff @(posedge vga_clk) begin
        if (push) fifo[wr_ptr] <= sel_dir;
    end
endmodule

// File: tb/tb_dir_input_queue.sv
// Self-checking bench for dir_input_queue: directed scenarios plus random presses/ticks,
// compared against a queue-based model of the turn rules (reversal lock follows DIR_REVERSE_LOCK_EN).
module tb_dir_input_queue;
    localparam int unsigned DEB   = 4;
    localparam int unsigned DEPTH = 2;
`ifdef DIR_REVERSE_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refresh = 1'b0;
    logic [3:0] sw = 4'b0000;
    logic [1:0] dir;
    logic       turn_pulse;
    logic [3:0] pending;
    logic       drop_pulse;

    int errors = 0;
    int checks = 0;

    // Model state: committed direction and queue of accepted turns.
    logic [1:0] mdir;
    logic [1:0] mq[$];

    dir_input_queue #(
        .DEBOUNCE_CYCLES(DEB),
        .QUEUE_DEPTH    (DEPTH),
        .RESET_DIR      (2'b11)
    ) dut (
        .vga_clk   (clk),
        .rst       (rst),
        .refresh   (refresh),
        .sw_up     (sw[0]),
        .sw_down   (sw[1]),
        .sw_left   (sw[2]),
        .sw_right  (sw[3]),
        .dir       (dir),
        .turn_pulse(turn_pulse),
        .pending   (pending),
        .drop_pulse(drop_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Hold the press long enough to debounce; the strobe cycle can coincide with a refresh.
    task automatic apply_step(input logic [3:0] mask, input bit do_refresh, input string tag);
        logic [1:0] d;
        logic [1:0] refv;
        bit pop, push, rej, exp_turn, exp_drop;
        sw = mask;
        repeat (DEB + 2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (pending !== 4'(mq.size())) begin
            errors++;
            $display("FAIL %s pending_before got=%0d want=%0d", tag, pending, mq.size());
        end
        refresh = do_refresh;

        pop      = do_refresh && (mq.size() > 0);
        push     = 1'b0;
        exp_drop = 1'b0;
        d        = 2'b00;
        if (mask != 4'b0000) begin
            if (mask[0])      d = 2'b00;
            else if (mask[1]) d = 2'b01;
            else if (mask[2]) d = 2'b10;
            else              d = 2'b11;
            refv = (mq.size() > 0) ? mq[$] : mdir;
            rej  = (d == refv) || (LOCK && (d[1] == refv[1]));
            if (!rej) begin
                if (mq.size() == DEPTH && !pop) exp_drop = 1'b1;
                else push = 1'b1;
            end
        end
        exp_turn = pop;
        if (pop) mdir = mq.pop_front();
        if (push) mq.push_back(d);

        @(negedge clk);
        refresh = 1'b0;
        sw      = 4'b0000;
        checks++;
        if (pending !== 4'(mq.size())) begin
            errors++;
            $display("FAIL %s pending got=%0d want=%0d", tag, pending, mq.size());
        end
        checks++;
        if (dir !== mdir) begin
            errors++;
            $display("FAIL %s dir got=%b want=%b", tag, dir, mdir);
        end
        checks++;
        if (turn_pulse !== exp_turn) begin
            errors++;
            $display("FAIL %s turn_pulse got=%b want=%b", tag, turn_pulse, exp_turn);
        end
        checks++;
        if (drop_pulse !== exp_drop) begin
            errors++;
            $display("FAIL %s drop_pulse got=%b want=%b", tag, drop_pulse, exp_drop);
        end
        @(negedge clk);
        checks++;
        if (turn_pulse !== 1'b0 || drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse_width turn=%b drop=%b want 0/0", tag, turn_pulse, drop_pulse);
        end
        repeat (DEB + 4) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        refresh = 1'b0;
        sw = 4'b0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mdir = 2'b11;
        mq.delete();
        checks++;
        if (dir !== 2'b11) begin
            errors++;
            $display("FAIL reset dir got=%b want=11", dir);
        end
        checks++;
        if (pending !== 4'd0) begin
            errors++;
            $display("FAIL reset pending got=%0d want=0", pending);
        end
        checks++;
        if (turn_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset turn_pulse got=%b want=0", turn_pulse);
        end
        checks++;
        if (drop_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset drop_pulse got=%b want=0", drop_pulse);
        end
    endtask

    task automatic test_debounce();
        test_reset();
        sw = 4'b0001;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sw = 4'b0000;
        repeat (DEB + 6) @(negedge clk);
        checks++;
        if (pending !== 4'd0) begin
            errors++;
            $display("FAIL glitch pending got=%0d want=0", pending);
        end
        apply_step(4'b0001, 1'b0, "debounce_hold");
        apply_step(4'b0000, 1'b1, "debounce_commit");
        checks++;
        if (dir !== 2'b00) begin
            errors++;
            $display("FAIL debounce_dir got=%b want=00", dir);
        end
    endtask

    task automatic test_queue();
        test_reset();
        apply_step(4'b0001, 1'b0, "queue_up");
        apply_step(4'b0100, 1'b0, "queue_left");
        apply_step(4'b0010, 1'b0, "queue_drop_down");
        apply_step(4'b0000, 1'b1, "queue_pop1");
        apply_step(4'b0000, 1'b1, "queue_pop2");
        checks++;
        if (dir !== 2'b10) begin
            errors++;
            $display("FAIL queue_final_dir got=%b want=10", dir);
        end
    endtask

    task automatic test_reverse();
        test_reset();
        apply_step(4'b0100, 1'b0, "reverse_left");
        apply_step(4'b0000, 1'b1, "reverse_commit");
    endtask

    task automatic test_full_simul();
        test_reset();
        apply_step(4'b0001, 1'b0, "full_up");
        apply_step(4'b0100, 1'b0, "full_left");
        apply_step(4'b0010, 1'b1, "full_down_with_pop");
        apply_step(4'b0000, 1'b1, "full_drain1");
        apply_step(4'b0000, 1'b1, "full_drain2");
    endtask

    task automatic test_priority_and_mid_reset();
        test_reset();
        apply_step(4'b1001, 1'b0, "prio_up_right");
        apply_step(4'b0000, 1'b1, "prio_commit");
        apply_step(4'b0100, 1'b0, "mid_left");
        apply_step(4'b0010, 1'b0, "mid_down");
        test_reset();
        apply_step(4'b0000, 1'b1, "post_reset_refresh");
    endtask

    task automatic test_random();
        logic [3:0] mask;
        bit         r;
        test_reset();
        for (int n = 0; n < 40; n++) begin
            mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) mask = 4'b0001 << $urandom_range(0, 3);
            r = 1'($urandom_range(0, 1));
            if (mask == 4'b0000) r = 1'b1;
            apply_step(mask, r, "random");
        end
    endtask

    initial begin
        mdir = 2'b11;
        test_reset();
        test_debounce();
        test_queue();
        test_reverse();
        test_full_simul();
        test_priority_and_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
